// File: rtl/tx_scrambler_framer_if.sv
// Bit-serial stream bundle between the PSDU source, the DATA-field framer and the encoder.
// The framer takes the slave side; the bit source / encoder model takes the master side.
interface tx_scrambler_framer_if;
    logic data_in;
    logic istream_val;
    logic istream_rdy;
    logic data_out;
    logic ostream_val;
    logic ostream_rdy;
    logic sym_last;

    modport master (
        output data_in, istream_val, ostream_rdy,
        input  istream_rdy, data_out, ostream_val, sym_last
    );

    modport slave (
        input  data_in, istream_val, ostream_rdy,
        output istream_rdy, data_out, ostream_val, sym_last
    );
endinterface

// File: rtl/tx_scrambler_framer.sv
// 802.11a DATA-field builder: SERVICE + PSDU + TAIL + PAD, scrambled with x^7+x^4+1,
// padded to whole OFDM symbols by letting the per-symbol bit counter wrap.
module tx_scrambler_framer #(
    parameter logic [6:0] DEFAULT_SEED = 7'b1011101,
    parameter int         LEN_W        = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       rate_i,
    input  logic [LEN_W-1:0] length_i,
    input  logic [6:0]       seed_i,
    tx_scrambler_framer_if.slave bits,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {IDLE, SERVICE, PSDU, TAIL, PAD, FLUSH} state_e;

    state_e      state_q;
    logic [6:0]  scr_q;
    logic [15:0] bitCnt_q;
    logic [15:0] psduLast_q;
    logic [15:0] tailLast_q;
    logic [7:0]  symCnt_q;
    logic [7:0]  nDbps_q;
    logic        dataOut_q;
    logic        ostreamVal_q;
    logic        symLast_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic        adv;
    logic        emit;
    logic        fb;
    logic        inBit;
    logic        outBit;
    logic        symWrap;
    logic        startOk;
    logic [7:0]  startDbps;
    logic [6:0]  scr_d;
    logic [7:0]  symCnt_d;
    logic [15:0] bitCnt_d;
    logic [15:0] lenBits;

    function automatic logic [7:0] dbpsOf(input logic [3:0] r);
        case (r)
            4'b1101: dbpsOf = 8'd24;
            4'b1111: dbpsOf = 8'd36;
            4'b0101: dbpsOf = 8'd48;
            4'b0111: dbpsOf = 8'd72;
            4'b1001: dbpsOf = 8'd96;
            4'b1011: dbpsOf = 8'd144;
            4'b0001: dbpsOf = 8'd192;
            4'b0011: dbpsOf = 8'd216;
            default: dbpsOf = 8'd0;
        endcase
    endfunction

    always_comb begin
        adv       = !ostreamVal_q | bits.ostream_rdy;
        inBit     = (state_q == PSDU) ? bits.data_in : 1'b0;
        emit      = adv & ((state_q == SERVICE) | (state_q == TAIL) | (state_q == PAD) |
                           ((state_q == PSDU) & bits.istream_val));
        fb        = scr_q[6] ^ scr_q[3];
        outBit    = (state_q == TAIL) ? 1'b0 : (inBit ^ fb);
        symWrap   = (symCnt_q == nDbps_q - 8'd1);
        scr_d     = {scr_q[5:0], fb};
        symCnt_d  = symWrap ? 8'd0 : symCnt_q + 8'd1;
        bitCnt_d  = bitCnt_q + 16'd1;
        startDbps = dbpsOf(rate_i);
        startOk   = (startDbps != 8'd0) && (length_i != '0);
        lenBits   = 16'(length_i) << 3;
    end

    assign bits.istream_rdy = (state_q == PSDU) & adv;
    assign bits.data_out    = dataOut_q;
    assign bits.ostream_val = ostreamVal_q;
    assign bits.sym_last    = symLast_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

    // Phase boundaries are absolute bit indices latched at start: PSDU ends at 8*len+15, TAIL at 8*len+21.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            scr_q        <= '0;
            bitCnt_q     <= '0;
            psduLast_q   <= '0;
            tailLast_q   <= '0;
            symCnt_q     <= '0;
            nDbps_q      <= '0;
            dataOut_q    <= 1'b0;
            ostreamVal_q <= 1'b0;
            symLast_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (startOk) begin
                            nDbps_q    <= startDbps;
                            psduLast_q <= lenBits + 16'd15;
                            tailLast_q <= lenBits + 16'd21;
                            scr_q      <= (seed_i == 7'd0) ? DEFAULT_SEED : seed_i;
                            bitCnt_q   <= '0;
                            symCnt_q   <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= SERVICE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (bits.ostream_rdy) begin
                        ostreamVal_q <= 1'b0;
                        symLast_q    <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    if (emit) begin
                        dataOut_q    <= outBit;
                        ostreamVal_q <= 1'b1;
                        symLast_q    <= symWrap;
                        scr_q        <= scr_d;
                        symCnt_q     <= symCnt_d;
                        bitCnt_q     <= bitCnt_d;
                        case (state_q)
                            SERVICE: if (bitCnt_q == 16'd15)   state_q <= PSDU;
                            PSDU:    if (bitCnt_q == psduLast_q) state_q <= TAIL;
                            TAIL:    if (bitCnt_q == tailLast_q) state_q <= symWrap ? FLUSH : PAD;
                            default: if (symWrap)              state_q <= FLUSH;
                        endcase
                    end else if (adv) begin
                        ostreamVal_q <= 1'b0;
                        symLast_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
